// File: rtl/sha3_512_unpadder.sv
// sha3_512_unpadder
//   Receive-side counterpart of the SHA3-512 padder. Takes one padded
//   72-byte rate block, checks the Keccak padding (domain byte 0x06, final
//   bit 0x80, or the merged 0x86 when the message fills 71 bytes), recovers
//   the message length by scanning backward from the block end, and streams
//   the message out as 64-bit words.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_block[575:0]   padded block, byte i = in_block[575-8i -: 8]
//   in_valid/in_ready block handshake
//   out_data[63:0]    message word, first byte in [63:56], unused bytes 0
//   out_valid/out_ready word handshake
//   out_last          high with the final word of the message
//   out_bytes[3:0]    valid bytes in the current word (1..8)
//   done              one-cycle pulse at the end of each block
//   err               padding error, qualified by done
//   msg_len[6:0]      recovered length, qualified by done, 0 on error
//
// Handshake semantics: a transfer happens on a rising clk edge where
// valid and ready are both high. valid never depends combinationally on
// ready; once out_valid is high, out_data/out_last/out_bytes hold until
// the word is taken.
//
// The FSM state is held in state_q (type state_t) for checker binding.

module sha3_512_unpadder (
  input  logic         clk,
  input  logic         reset,
  input  logic [575:0] in_block,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [63:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [3:0]   out_bytes,
  output logic         done,
  output logic         err,
  output logic [6:0]   msg_len
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SCAN  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [575:0]   buf_q, buf_d;
  logic [6:0]     idx_q, idx_d;
  logic [6:0]     len_q, len_d;
  logic [3:0]     wcnt_q, wcnt_d;

  // Byte view of the buffer: buf_bytes[i] is message byte i.
  logic [7:0]     buf_bytes [0:71];
  logic [7:0]     scan_byte;
  logic [7:0]     tail_byte;
  logic [3:0]     nw;
  logic           last_word;
  logic [6:0]     pos;

  always_comb begin
    for (int i = 0; i < 72; i++) begin
      buf_bytes[i] = buf_q[575-8*i -: 8];
    end
  end

  assign scan_byte = buf_bytes[idx_q];
  assign tail_byte = buf_bytes[71];
  // Word count ceil(len/8); len never exceeds 71, so len+7 fits in 7 bits.
  assign nw        = 4'((len_q + 7'd7) >> 3);
  assign last_word = (wcnt_q == (nw - 4'd1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          buf_d   = in_block;
          wcnt_d  = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (tail_byte == 8'h86) begin
          // Domain byte and final bit share byte 71: 71-byte message.
          len_d   = 7'd71;
          state_d = S_EMIT;
        end else if (tail_byte == 8'h80) begin
          idx_d   = 7'd70;
          state_d = S_SCAN;
        end else begin
          state_d = S_ERR;
        end
      end
      S_SCAN: begin
        if (scan_byte == 8'h00) begin
          if (idx_q != 7'd0) begin
            idx_d = idx_q - 7'd1;
          end else begin
            state_d = S_ERR;
          end
        end else if (scan_byte == 8'h06) begin
          len_d   = idx_q;
          state_d = (idx_q != 7'd0) ? S_EMIT : S_DONE;
        end else begin
          state_d = S_ERR;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          wcnt_d = wcnt_q + 4'd1;
          if (last_word) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        wcnt_d  = '0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        wcnt_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs, decoded from the registered state
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_EMIT);
    out_data  = '0;
    out_last  = 1'b0;
    out_bytes = '0;
    done      = 1'b0;
    err       = 1'b0;
    msg_len   = '0;
    pos       = '0;
    case (state_q)
      S_EMIT: begin
        for (int j = 0; j < 8; j++) begin
          pos = {wcnt_q, 3'b000} + 7'(j);
          // Bytes at or past the message end are padding; blank them.
          out_data[63-8*j -: 8] = (pos < len_q) ? buf_bytes[pos] : 8'h00;
        end
        out_last  = last_word;
        out_bytes = last_word ? 4'(len_q - {wcnt_q, 3'b000}) : 4'd8;
      end
      S_DONE: begin
        done    = 1'b1;
        msg_len = len_q;
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
